// File: rtl/rca_slice_sequencer.sv
// Multi-cycle add/subtract sequencer: one SLICE-bit ripple adder is stepped
// LSB-first over WIDTH-bit operands, carry chained between chunks.
module rca_slice_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cr_q, cr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_a, slice_b, slice_s;
  logic [SLICE:0]   rc;

  // Bit-serial ripple through the current chunk, exactly as the adder slice.
  always_comb begin
    slice_a = a_q[idx_q*SLICE +: SLICE];
    slice_b = b_q[idx_q*SLICE +: SLICE];
    slice_s = '0;
    rc      = '0;
    rc[0]   = cr_q;
    for (int i = 0; i < SLICE; i++) begin
      slice_s[i] = slice_a[i] ^ slice_b[i] ^ rc[i];
      rc[i+1]    = (slice_a[i] & slice_b[i]) | (rc[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cr_d    = cr_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op ? ~b : b;
          cr_d    = op ? 1'b1 : c_in;
          idx_d   = '0;
          sum_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_s;
        cr_d  = rc[SLICE];
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          carry_d = rc[SLICE];
          // Overflow from operand signs vs. result sign (B already inverted for subtract).
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_s[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cr_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cr_q    <= cr_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Scoreboard bench for rca_slice_sequencer: driver pushes expected results,
// a negedge monitor compares whenever out_valid is presented.
module tb_rca_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;
  logic        ovf;
  logic        busy;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rca_slice_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares while the result is presented (stall cycles included), pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sum", 32'(sum), 32'(exp_q[0].s));
        check("carry", 32'(carry), 32'(exp_q[0].c));
        check("ovf", 32'(ovf), 32'(exp_q[0].o));
        $display("result sum=0x%04h carry=%0b ovf=%0b out_ready=%0b", sum, carry, ovf, out_ready);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic op_v, input logic [15:0] av,
                        input logic [15:0] bv, input logic cin, input logic [15:0] es,
                        input logic ec, input logic eo, input int stall);
    int lat;
    exp_t e;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = op_v;
    a         = av;
    b         = bv;
    c_in      = cin;
    out_ready = 1'b0;
    $display("issue %s op=%0b a=0x%04h b=0x%04h c_in=%0b", nm, op_v, av, bv, cin);
    @(posedge clk);
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    op       = ~op_v;
    c_in     = ~cin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      check({nm, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      check({nm, "_busy"}, 32'(busy), 32'd1);
    end
    check({nm, "_latency"}, 32'(lat), 32'd4);
    if (!out_valid) exp_q.delete();
    // Offer a competing request during backpressure; it must not be accepted.
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = 16'h1111;
      b        = 16'h2222;
      @(posedge clk);
      #1;
      check({nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      check({nm, "_stall_out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, "_post_out_valid"}, 32'(out_valid), 32'd0);
    check({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_post_busy"}, 32'(busy), 32'd0);
    check({nm, "_scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    c_in      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_basic",   1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("add_ripple",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ovf",     1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("add_cin",     1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
    run_op("sub_borrow",  1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf",     1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("add_stall",   1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 3);
    run_op("add_after",   1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 0);

    // Abort an operation two RUN cycles in with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    op       = 1'b0;
    c_in     = 1'b1;
    $display("issue abort op=0 a=0xffff b=0xffff c_in=1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_reset", 1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
